// File: rtl/led_anim_ctrl.sv
// LED matrix animation control: scan/frame timebase, button debounce,
// RUN/PAUSE/STILL mode FSM and frame-select sequencing.
module led_anim_ctrl #(
  parameter int SCAN_DIV    = 5000,
  parameter int FRAME_SCANS = 200,
  parameter int DEB_CYCLES  = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_step,
  output logic       scan_tick,
  output logic       frame_tick,
  output logic [1:0] sel,
  output logic       pattern,
  output logic [1:0] mode
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int FW = $clog2(FRAME_SCANS);
  localparam int DW = $clog2(DEB_CYCLES);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    PAUSE = 2'b01,
    STILL = 2'b10
  } state_t;

  logic [SW-1:0] sc;
  logic [FW-1:0] fc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc        <= '0;
      scan_tick <= 1'b0;
    end else if (sc == SW'(SCAN_DIV - 1)) begin
      sc        <= '0;
      scan_tick <= 1'b1;
    end else begin
      sc        <= sc + 1'b1;
      scan_tick <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fc <= '0;
    end else if (scan_tick) begin
      if (fc == FW'(FRAME_SCANS - 1))
        fc <= '0;
      else
        fc <= fc + 1'b1;
    end
  end

  assign frame_tick = scan_tick && (fc == FW'(FRAME_SCANS - 1));

  // Bit 0 is the mode button, bit 1 the step button.
  logic [1:0]    btn;
  logic [1:0]    s1;
  logic [1:0]    s2;
  logic [1:0]    deb;
  logic [1:0]    deb_d;
  logic [1:0]    press;
  logic [DW-1:0] dc [2];

  assign btn = {btn_step, btn_mode};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= '0;
      s2    <= '0;
      deb   <= '0;
      deb_d <= '0;
      press <= '0;
      dc[0] <= '0;
      dc[1] <= '0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      deb_d <= deb;
      press <= deb & ~deb_d;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == deb[i]) begin
          dc[i] <= '0;
        end else if (dc[i] == DW'(DEB_CYCLES - 1)) begin
          deb[i] <= s2[i];
          dc[i]  <= '0;
        end else begin
          dc[i] <= dc[i] + 1'b1;
        end
      end
    end
  end

  logic   mode_press;
  logic   step_press;
  state_t state_q;
  state_t state_d;
  logic [1:0] sel_d;
  logic   pattern_d;

  assign mode_press = press[0];
  assign step_press = press[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      sel     <= 2'd0;
      pattern <= 1'b0;
    end else begin
      state_q <= state_d;
      sel     <= sel_d;
      pattern <= pattern_d;
    end
  end

  // A mode press always wins; the frame select only moves when it is absent.
  always_comb begin
    state_d = state_q;
    sel_d   = sel;
    if (mode_press) begin
      case (state_q)
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = STILL;
        STILL:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end else if (state_q == RUN && frame_tick) begin
      sel_d = sel + 2'd1;
    end else if (state_q == PAUSE && step_press) begin
      sel_d = sel + 2'd1;
    end
    pattern_d = (state_d == STILL);
  end

  assign mode = state_q;

endmodule

// File: tb/tb_led_anim_ctrl.sv
// Directed bench for led_anim_ctrl with small timing parameters.
// Checkpoints are indexed by rising edges counted from reset release.
module tb_led_anim_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_mode;
  logic       btn_step;
  logic       scan_tick;
  logic       frame_tick;
  logic [1:0] sel;
  logic       pattern;
  logic [1:0] mode;

  led_anim_ctrl #(
    .SCAN_DIV(4),
    .FRAME_SCANS(8),
    .DEB_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_mode(btn_mode),
    .btn_step(btn_step),
    .scan_tick(scan_tick),
    .frame_tick(frame_tick),
    .sel(sel),
    .pattern(pattern),
    .mode(mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         e;
    logic       bm;
    logic       bs;
    logic [6:0] exp;
  } vec_t;

  vec_t v[$];
  int   e;
  int   total;
  int   bad;

  function automatic vec_t mk(int at, bit bm, bit bs, bit sc,
                              bit fr, int sl, bit pt, int md);
    vec_t r;
    r.e   = at;
    r.bm  = bm;
    r.bs  = bs;
    r.exp = {sc, fr, 2'(sl), pt, 2'(md)};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    e++;
  endtask

  task automatic chk(input string name, input logic [6:0] want);
    logic [6:0] got;
    got = {scan_tick, frame_tick, sel, pattern, mode};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got{scan,frame,sel,pat,mode}=%b want=%b",
               name, got, want);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    e        = 0;
    rst      = 1'b1;
    btn_mode = 1'b0;
    btn_step = 1'b0;

    //         e   bm bs  sc fr sel pt md
    v.push_back(mk(0,   0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(3,   0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(4,   0, 0, 1, 0, 0, 0, 0));
    v.push_back(mk(5,   0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(32,  0, 0, 1, 1, 0, 0, 0));
    v.push_back(mk(33,  0, 0, 0, 0, 1, 0, 0));
    v.push_back(mk(64,  0, 0, 1, 1, 1, 0, 0));
    v.push_back(mk(65,  0, 0, 0, 0, 2, 0, 0));
    v.push_back(mk(97,  0, 0, 0, 0, 3, 0, 0));
    v.push_back(mk(128, 0, 0, 1, 1, 3, 0, 0));
    v.push_back(mk(129, 0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(200, 1, 0, 1, 0, 2, 0, 0));
    v.push_back(mk(206, 1, 0, 0, 0, 2, 0, 0));
    v.push_back(mk(207, 1, 0, 0, 0, 2, 0, 1));
    v.push_back(mk(220, 0, 0, 1, 0, 2, 0, 1));
    v.push_back(mk(224, 0, 0, 1, 1, 2, 0, 1));
    v.push_back(mk(225, 0, 0, 0, 0, 2, 0, 1));
    v.push_back(mk(230, 0, 1, 0, 0, 2, 0, 1));
    v.push_back(mk(236, 0, 1, 1, 0, 2, 0, 1));
    v.push_back(mk(237, 0, 1, 0, 0, 3, 0, 1));
    v.push_back(mk(240, 0, 0, 1, 0, 3, 0, 1));
    v.push_back(mk(250, 0, 1, 0, 0, 3, 0, 1));
    v.push_back(mk(256, 0, 1, 1, 1, 3, 0, 1));
    v.push_back(mk(257, 0, 1, 0, 0, 0, 0, 1));
    v.push_back(mk(260, 0, 0, 1, 0, 0, 0, 1));
    v.push_back(mk(270, 0, 1, 0, 0, 0, 0, 1));
    v.push_back(mk(272, 0, 0, 1, 0, 0, 0, 1));
    v.push_back(mk(289, 0, 0, 0, 0, 0, 0, 1));
    v.push_back(mk(300, 1, 0, 1, 0, 0, 0, 1));
    v.push_back(mk(306, 1, 0, 0, 0, 0, 0, 1));
    v.push_back(mk(307, 1, 0, 0, 0, 0, 1, 2));
    v.push_back(mk(320, 0, 0, 1, 1, 0, 1, 2));
    v.push_back(mk(321, 0, 0, 0, 0, 0, 1, 2));
    v.push_back(mk(353, 0, 0, 0, 0, 0, 1, 2));
    v.push_back(mk(385, 0, 0, 0, 0, 0, 1, 2));
    v.push_back(mk(390, 1, 0, 0, 0, 0, 1, 2));
    v.push_back(mk(397, 1, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(410, 0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(416, 0, 0, 1, 1, 0, 0, 0));
    v.push_back(mk(417, 0, 0, 0, 0, 1, 0, 0));
    v.push_back(mk(442, 1, 0, 0, 0, 1, 0, 0));
    v.push_back(mk(448, 1, 0, 1, 1, 1, 0, 0));
    v.push_back(mk(449, 1, 0, 0, 0, 1, 0, 1));
    v.push_back(mk(460, 0, 0, 1, 0, 1, 0, 1));
    v.push_back(mk(474, 1, 1, 0, 0, 1, 0, 1));
    v.push_back(mk(480, 1, 1, 1, 1, 1, 0, 1));
    v.push_back(mk(481, 1, 1, 0, 0, 1, 1, 2));
    v.push_back(mk(490, 0, 0, 0, 0, 1, 1, 2));
    v.push_back(mk(500, 0, 1, 1, 0, 1, 1, 2));
    v.push_back(mk(508, 0, 1, 1, 0, 1, 1, 2));
    v.push_back(mk(510, 0, 0, 0, 0, 1, 1, 2));
    v.push_back(mk(513, 0, 0, 0, 0, 1, 1, 2));
    v.push_back(mk(520, 1, 0, 1, 0, 1, 1, 2));
    v.push_back(mk(526, 1, 0, 0, 0, 1, 1, 2));
    v.push_back(mk(527, 1, 0, 0, 0, 1, 0, 0));
    v.push_back(mk(530, 1, 1, 0, 0, 1, 0, 0));
    v.push_back(mk(538, 1, 1, 0, 0, 1, 0, 0));
    v.push_back(mk(540, 0, 0, 1, 0, 1, 0, 0));
    v.push_back(mk(544, 0, 0, 1, 1, 1, 0, 0));
    v.push_back(mk(545, 0, 0, 0, 0, 2, 0, 0));
    v.push_back(mk(550, 1, 0, 0, 0, 2, 0, 0));
    v.push_back(mk(553, 1, 0, 0, 0, 2, 0, 0));
    v.push_back(mk(556, 1, 0, 1, 0, 2, 0, 0));

    repeat (3) @(negedge clk);
    rst = 1'b0;
    e   = 0;

    for (int i = 0; i < v.size(); i++) begin
      while (e < v[i].e) tick();
      chk($sformatf("vec%0d_e%0d", i, v[i].e), v[i].exp);
      btn_mode = v[i].bm;
      btn_step = v[i].bs;
    end

    // Asynchronous reset mid-frame and mid-debounce, btn_mode still held.
    rst = 1'b1;
    #1;
    chk("rst_async", 7'b0000000);
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold", 7'b0000000);
    rst = 1'b0;
    e   = 0;
    repeat (3) tick();
    chk("post_rst_e3", 7'b0000000);
    tick();
    chk("post_rst_e4_scan", 7'b1000000);
    repeat (2) tick();
    chk("post_rst_e6_mode", 7'b0000000);
    tick();
    chk("post_rst_e7_mode", 7'b0000001);
    btn_mode = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
